// File: rtl/im_loader_pkg.sv
// Shared definitions for the IM program loader.
// State encoding, frame constants and the length check.
package im_loader_pkg;

  localparam int IM_AW = 6;
  localparam logic [7:0] SYNC_BYTE_D = 8'hA5;
  localparam int TIMEOUT_D = 1_000_000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } ld_state_t;

  // A frame must carry 1..2^aw words.
  function automatic logic len_ok(
    input logic [7:0] n,
    input int         aw
  );
    return (n != 8'd0) && (int'(n) <= (1 << aw));
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog for the loader.
// Reloads on every restart; expired once it has counted down to zero.
module loader_timeout #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= W'(TIMEOUT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/im_loader.sv
// Framed byte-stream loader writing 32-bit words into IM.
// Holds the CPU while armed; reports progress and sticky status.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int         ADDR_W    = IM_AW,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_D,
  parameter int         TIMEOUT   = TIMEOUT_D
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  ld_state_t       state;
  logic [ADDR_W:0] n_words;
  logic [7:0]      csum;
  logic [7:0]      csum_nx;
  logic [1:0]      byte_idx;
  logic [23:0]     word_lo;
  logic            active;
  logic            expired;

  assign active = (state == S_LEN) ||
                  (state == S_DATA) ||
                  (state == S_CSUM);
  assign csum_nx = csum + rx_data;

  // Watchdog only runs while a frame is open.
  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .restart(rx_valid | ~active),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      state        <= S_IDLE;
      n_words      <= '0;
      csum         <= '0;
      byte_idx     <= '0;
      word_lo      <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      im_we    <= 1'b0;
      cpu_hold <= load_en;
      if (!load_en) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
        err   <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            state        <= S_SYNC;
            words_loaded <= '0;
          end
          S_SYNC: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
              state <= S_LEN;
              busy  <= 1'b1;
            end
          end
          S_LEN: begin
            if (rx_valid) begin
              if (len_ok(rx_data, ADDR_W)) begin
                state        <= S_DATA;
                n_words      <= (ADDR_W+1)'(rx_data);
                csum         <= rx_data;
                byte_idx     <= '0;
                words_loaded <= '0;
              end else begin
                state <= S_ERR;
                err   <= 1'b1;
                busy  <= 1'b0;
              end
            end else if (expired) begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
          S_DATA: begin
            if (rx_valid) begin
              csum     <= csum_nx;
              byte_idx <= byte_idx + 1'b1;
              unique case (byte_idx)
                2'd0: word_lo[7:0]   <= rx_data;
                2'd1: word_lo[15:8]  <= rx_data;
                2'd2: word_lo[23:16] <= rx_data;
                2'd3: begin
                  im_we        <= 1'b1;
                  im_addr      <= words_loaded[ADDR_W-1:0];
                  im_wdata     <= {rx_data, word_lo};
                  words_loaded <= words_loaded + 1'b1;
                  if (words_loaded + 1'b1 == n_words)
                    state <= S_CSUM;
                end
              endcase
            end else if (expired) begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
          S_CSUM: begin
            if (rx_valid) begin
              busy <= 1'b0;
              if (csum_nx == 8'h00) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_ERR;
                err   <= 1'b1;
              end
            end else if (expired) begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
          S_DONE, S_ERR: begin
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader.
// Fixed frame vectors, hand corner sequences and random frames.
module tb_im_loader;

  localparam int AW  = 6;
  localparam int TO  = 100;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          load_en = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  logic [31:0]   ed[$];

  typedef struct {
    int          len;
    logic [95:0] b;
    logic        dn;
    logic        er;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vt[5];

  im_loader #(
    .ADDR_W   (AW),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .load_en     (load_en),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wa.push_back(im_addr);
      wd.push_back(im_wdata);
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic arm();
    wa.delete();
    wd.delete();
    ed.delete();
    load_en = 1'b1;
    tick();
    tick();
  endtask

  task automatic disarm();
    load_en = 1'b0;
    tick();
    chk("disarm_hold", cpu_hold, 0);
    chk("disarm_done", done, 0);
    chk("disarm_err", err, 0);
    tick();
  endtask

  task automatic check_frame(
    input logic dn,
    input logic er,
    input int   nw
  );
    chk("done", done, dn);
    chk("err", err, er);
    chk("busy", busy, 0);
    chk("hold", cpu_hold, 1);
    chk("words_loaded", words_loaded, nw);
    chk("wr_count", wa.size(), ed.size());
    for (int k = 0; k < ed.size(); k++) begin
      if (k < wa.size()) begin
        chk("wr_addr", wa[k], k);
        chk("wr_data", wd[k], ed[k]);
      end
    end
  endtask

  task automatic run_random(input int frames);
    int          n;
    int          sel;
    int          sum;
    int          gmax;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [31:0] w;
    logic        ok;
    for (int f = 0; f < frames; f++) begin
      sel = $urandom_range(0, 9);
      gmax = $urandom_range(0, 2);
      if (sel == 0) n = 0;
      else if (sel == 1) n = $urandom_range(CAP + 1, 255);
      else if (sel == 2) n = CAP;
      else n = $urandom_range(1, 12);
      arm();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send(b, $urandom_range(0, gmax));
      end
      send(8'hA5, $urandom_range(0, gmax));
      send(8'(n), $urandom_range(0, gmax));
      if (n >= 1 && n <= CAP) begin
        sum = n;
        for (int i = 0; i < n; i++) begin
          w = $urandom;
          ed.push_back(w);
          for (int j = 0; j < 4; j++) begin
            send(w[8*j +: 8], $urandom_range(0, gmax));
            sum += int'(w[8*j +: 8]);
          end
        end
        c = 8'((256 - (sum % 256)) % 256);
        if ($urandom_range(0, 3) == 0)
          c = c + 8'($urandom_range(1, 255));
        send(c, 0);
        ok = ((sum + int'(c)) % 256) == 0;
        check_frame(ok, !ok, n);
      end else begin
        check_frame(1'b0, 1'b1, 0);
      end
      disarm();
    end
  endtask

  initial begin
    int n;

    vt[0] = '{len: 7, dn: 1'b1, er: 1'b0, nw: 1,
              w0: 32'h00000013, w1: 32'h0,
              b: {8'hA5, 8'h01, 8'h13, 8'h00, 8'h00,
                  8'h00, 8'hEC, 40'h0}};
    vt[1] = '{len: 12, dn: 1'b1, er: 1'b0, nw: 2,
              w0: 32'h04030201, w1: 32'h08070605,
              b: {8'h00, 8'hFF, 8'hA5, 8'h02,
                  8'h01, 8'h02, 8'h03, 8'h04,
                  8'h05, 8'h06, 8'h07, 8'h08}};
    vt[1].b[7:0] = 8'h08;
    vt[2] = '{len: 7, dn: 1'b0, er: 1'b1, nw: 1,
              w0: 32'h00000013, w1: 32'h0,
              b: {8'hA5, 8'h01, 8'h13, 8'h00, 8'h00,
                  8'h00, 8'h00, 40'h0}};
    vt[3] = '{len: 2, dn: 1'b0, er: 1'b1, nw: 0,
              w0: 32'h0, w1: 32'h0,
              b: {8'hA5, 8'h00, 80'h0}};
    vt[4] = '{len: 2, dn: 1'b0, er: 1'b1, nw: 0,
              w0: 32'h0, w1: 32'h0,
              b: {8'hA5, 8'h41, 80'h0}};

    // reset state
    repeat (3) tick();
    chk("rst_we", im_we, 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_wdata", im_wdata, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words", words_loaded, 0);
    rstn = 1'b0;
    tick();

    // fixed frame vectors (vector 1 csum byte appended below)
    for (int v = 0; v < 5; v++) begin
      arm();
      if (vt[v].nw >= 1) ed.push_back(vt[v].w0);
      if (vt[v].nw >= 2) ed.push_back(vt[v].w1);
      for (int i = 0; i < vt[v].len; i++)
        send(vt[v].b[95-8*i -: 8], 0);
      if (v == 1) send(8'hDA, 0);
      check_frame(vt[v].dn, vt[v].er, vt[v].nw);
      disarm();
    end

    // write latency and hold behaviour
    arm();
    send(8'hA5, 0);
    send(8'h01, 0);
    chk("len_busy", busy, 1);
    send(8'h13, 1);
    send(8'h00, 0);
    send(8'h00, 2);
    chk("pre_we", im_we, 0);
    send(8'h00, 0);
    chk("lat_we", im_we, 1);
    chk("lat_addr", im_addr, 0);
    chk("lat_data", im_wdata, 32'h13);
    chk("lat_words", words_loaded, 1);
    tick();
    chk("post_we", im_we, 0);
    chk("hold_addr", im_addr, 0);
    chk("hold_data", im_wdata, 32'h13);
    send(8'hEC, 0);
    chk("lat_done", done, 1);
    disarm();

    // inter-byte timeout
    arm();
    send(8'hA5, 0);
    send(8'h02, 0);
    for (int i = 1; i <= 5; i++) send(8'(i), 0);
    n = 0;
    while (err !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_writes", wa.size(), 1);
    chk("timeout_busy", busy, 0);
    disarm();

    // abort mid-DATA, with a byte in the abort cycle
    arm();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    load_en  = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h04;
    tick();
    rx_valid = 1'b0;
    chk("abort_we", im_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_hold", cpu_hold, 0);
    tick();
    tick();
    chk("abort_writes", wa.size(), 0);

    // synchronous reset mid-DATA, then a clean reload
    arm();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    chk("pre_rst_we", im_we, 1);
    rstn = 1'b1;
    tick();
    chk("mid_rst_we", im_we, 0);
    chk("mid_rst_addr", im_addr, 0);
    chk("mid_rst_wdata", im_wdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_words", words_loaded, 0);
    rstn = 1'b0;
    wa.delete();
    wd.delete();
    ed.delete();
    tick();
    tick();
    ed.push_back(32'h00000013);
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h13, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'hEC, 0);
    check_frame(1'b1, 1'b0, 1);
    disarm();

    run_random(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
